dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the memory end of the CPU core's load/store port.
//  - Accepts MemRead/MemWrite requests from the core over a ready/valid handshake.
//  - Performs byte, half and word accesses on an internal word array.
//  - Returns load data, with sign/zero extension, after a fixed, parameterised latency.
//  - Replaces the single-cycle RAM so the core's stall path can be exercised.
// PARAMETERS
//  ADDR_W   10  byte-address width; array depth = 2**(ADDR_W-2) words
//  LATENCY  2   cycles from request acceptance to mem_valid; legal range 1..15
// PORTS
//  CLK         in   1       clock, all state on rising edge
//  RST         in   1       synchronous, active-high reset
//  MemRead     in   1       load request
//  MemWrite    in   1       store request
//  funct3      in   3       RV32I size/sign: 0 LB,1 LH,2 LW,4 LBU,5 LHU (stores use 0/1/2)
//  address     in   ADDR_W  byte address
//  write_data  in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  mem_ready   out  1       responder idle; request accepted this cycle if asserted
//  mem_valid   out  1       one-cycle pulse: access complete
//  mem_error   out  1       qualifies mem_valid: misaligned or illegal request
//  read_data   out  32      load result, valid only while mem_valid=1
// BEHAVIOUR
//  Reset: mem_ready=1; mem_valid, mem_error and read_data are 0.
//   FSM returns to IDLE; any in-flight access is aborted with no write commit.
//   Array contents are not reset.
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: mem_ready=1. On (MemRead|MemWrite), latch address, funct3,
//    write_data and the op, load cnt=LATENCY-1, then go BUSY.
//  - BUSY: mem_ready=0. Decrement cnt; at cnt==0 go RESP.
//    With LATENCY=1, BUSY lasts 0 cycles (IDLE -> RESP directly).
//  - RESP: mem_valid=1 for exactly one cycle, mem_ready=0.
//    Stores commit their byte lanes on this edge. Next state is IDLE.
//  - Accepted request at edge N: mem_valid is high in cycle N+LATENCY.
//    Next acceptance is possible at edge N+LATENCY+1.
//  - Request inputs are ignored while mem_ready=0; the initiator holds
//    them until it observes mem_ready.
//  Errors (mem_error=1 with mem_valid, same latency, no array update, read_data=0):
//  - MemRead and MemWrite both high.
//  - Half access with addr[0]=1; word access with addr[1:0]!=0.
//  - funct3 in {3,6,7}, or a store with funct3 in {4,5}.
//  Lanes: word index = addr[ADDR_W-1:2].
//  - Byte lane = addr[1:0]; half lane = addr[1].
//  - Store: only the selected lanes are written; the other lanes are unchanged.
//  - Load: selected lanes are shifted to bit 0.
//    Funct3 0/1 sign-extend from bit 7/15; funct3 4/5 zero-extend.
//  Addresses wrap modulo 2**ADDR_W; there is no out-of-range error.
//  Reads use the array contents as of acceptance plus any earlier committed
//  stores; there is no forwarding hazard because only one access is in flight.
// STRUCTURE
//  Shared package riscv_pkg:
//  - mem_size_t enum (LB, LH, LW, LBU, LHU).
//  - Constants for funct3 encodings.
//  - dmem_state_t enum (IDLE, BUSY, RESP).
//  Sub-module lsu_align (combinational):
//  - Inputs: funct3, addr[1:0], store data, raw read word.
//  - Outputs: 4-bit byte enable, lane-shifted store word, extended load word,
//    misalign/illegal flag.
//  - Reusable by the core's future load/store unit.
//  Top level holds the FSM, latency counter ($clog2(LATENCY+1) bits),
//  request registers and the array.
// TESTING
//  1 SW 0xDEADBEEF @0x010, then LW @0x010 -> mem_valid at +2 after acceptance,
//    read_data=0xDEADBEEF, mem_error=0
//  2 SB 0x80 @0x013, then LB @0x013 -> read_data=0xFFFFFF80;
//    LBU @0x013 -> 0x00000080; LW @0x010 -> 0x80ADBEEF
//  3 SH 0x1234 @0x012; LH @0x011 -> mem_error=1, read_data=0;
//    LW @0x010 -> 0x1234BEEF (misaligned access wrote nothing)
//  4 MemRead=MemWrite=1 @0x020 -> mem_valid+mem_error at +LATENCY, word 0x020 unchanged;
//    also request held high through BUSY -> exactly one acceptance, one mem_valid pulse
//  5 SW 0xCAFEF00D @0x030, RST=1 in the BUSY cycle -> next cycle mem_ready=1,
//    mem_valid=0; LW @0x030 returns the prior value
//  6 LATENCY=1 build: back-to-back LW @0x3FC then @0x000 -> mem_valid at cycles N+1, N+3;
//    wrap check: SW @0x3FC then LW @0x3FC -> same data

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 load/store definitions.
//  - funct3 encodings for memory accesses (sizes and signedness)
//  - mem_size_t: named access sizes
//  - dmem_state_t: data-memory responder FSM states
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Load/store lane alignment (combinational).
//  i_funct3      access size/sign (RV32I load/store funct3)
//  i_is_store    access is a store (funct3 4/5 are then illegal)
//  i_addr        low two bits of the byte address
//  i_store_data  right-aligned store data
//  i_raw_word    word read from memory
//  o_byte_en     lanes to write for a store (zero on error)
//  o_store_word  store data replicated onto every candidate lane
//  o_load_word   selected lanes shifted to bit 0, sign/zero extended (zero on error)
//  o_error       misaligned access or illegal funct3
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_raw_word,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_store_word,
    output logic [31:0] o_load_word,
    output logic        o_error
);

    logic [31:0] w_shifted;

    assign w_shifted = i_raw_word >> {i_addr, 3'b000};

    always_comb begin
        o_byte_en    = 4'b0000;
        o_store_word = '0;
        o_load_word  = '0;
        o_error      = 1'b0;
        case (i_funct3)
            F3_LB, F3_LBU: begin
                o_byte_en    = 4'b0001 << i_addr;
                o_store_word = {4{i_store_data[7:0]}};
                // funct3[2] set means unsigned variant
                o_load_word  = {{24{w_shifted[7] & ~i_funct3[2]}}, w_shifted[7:0]};
            end
            F3_LH, F3_LHU: begin
                o_error      = i_addr[0];
                o_byte_en    = i_addr[1] ? 4'b1100 : 4'b0011;
                o_store_word = {2{i_store_data[15:0]}};
                o_load_word  = {{16{w_shifted[15] & ~i_funct3[2]}}, w_shifted[15:0]};
            end
            F3_LW: begin
                o_error      = (i_addr != 2'b00);
                o_byte_en    = 4'b1111;
                o_store_word = i_store_data;
                o_load_word  = i_raw_word;
            end
            default: begin
                o_error = 1'b1;
            end
        endcase
        // There are no unsigned stores
        if (i_is_store && i_funct3[2]) begin
            o_error = 1'b1;
        end
        if (o_error) begin
            o_byte_en   = 4'b0000;
            o_load_word = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: memory end of the core's load/store port, with a
// fixed request-to-response latency so the core's stall path gets exercised.
//  CLK, RST     clock; synchronous active-high reset
//  MemRead      load request
//  MemWrite     store request
//  funct3       access size/sign
//  address      byte address (wraps modulo 2**ADDR_W)
//  write_data   right-aligned store data
//  mem_ready    idle; a request is accepted on this edge when asserted
//  mem_valid    one-cycle completion pulse
//  mem_error    qualifies mem_valid: misaligned or illegal request
//  read_data    load result while mem_valid (zero otherwise)
//
//  state | meaning
//  IDLE  | ready; latch request on MemRead|MemWrite
//  BUSY  | latency countdown; inputs ignored
//  RESP  | mem_valid pulse; stores commit on the closing edge
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic              mem_ready,
    output logic              mem_valid,
    output logic              mem_error,
    output logic [31:0]       read_data
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam int CNT_W = $clog2(LATENCY + 1);

    dmem_state_t         r_state;
    dmem_state_t         w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_funct3;
    logic [31:0]         r_wdata;
    logic                r_rd;
    logic                r_wr;
    logic [31:0]         r_mem [DEPTH];

    logic                w_accept;
    logic [ADDR_W-3:0]   w_word_idx;
    logic [31:0]         w_raw_word;
    logic [3:0]          w_byte_en;
    logic [31:0]         w_store_word;
    logic [31:0]         w_load_word;
    logic                w_align_err;
    logic                w_err;

    assign w_accept   = (r_state == IDLE) && (MemRead || MemWrite);
    assign w_word_idx = r_addr[ADDR_W-1:2];
    assign w_raw_word = r_mem[w_word_idx];

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_is_store   (r_wr),
        .i_addr       (r_addr[1:0]),
        .i_store_data (r_wdata),
        .i_raw_word   (w_raw_word),
        .o_byte_en    (w_byte_en),
        .o_store_word (w_store_word),
        .o_load_word  (w_load_word),
        .o_error      (w_align_err)
    );

    assign w_err = (r_rd && r_wr) || w_align_err;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_cnt_next   = CNT_W'(LATENCY - 1);
                    // Single-cycle latency skips BUSY entirely
                    w_state_next = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                w_cnt_next = r_cnt - 1'b1;
                // Leave on the edge where the count reaches zero
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_wdata  <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_addr   <= address;
                r_funct3 <= funct3;
                r_wdata  <= write_data;
                r_rd     <= MemRead;
                r_wr     <= MemWrite;
            end
        end
    end

    // Array is not reset; a reset landing on the RESP edge still blocks the commit
    always_ff @(posedge CLK) begin
        if (!RST && (r_state == RESP) && r_wr && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_word_idx][8*i +: 8] <= w_store_word[8*i +: 8];
                end
            end
        end
    end

    assign mem_ready = (r_state == IDLE);
    assign mem_valid = (r_state == RESP);
    assign mem_error = mem_valid && w_err;
    assign read_data = (mem_valid && r_rd && !w_err) ? w_load_word : 32'h0;

endmodule
